decim_stat_capture: RTL and testbench

//  Multi-channel decimating statistics capture engine: after arm + trigger + hold-off, reduces each block of
//  2^log2n input samples per channel to one output word: floor/rounded mean, min, max or peak-to-peak.

---
 rtl/decim_stat_capture.sv | 202 ++++++++++++++++++++
 tb/tb_decim_stat_capture.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decim_stat_capture.sv
// Multi-channel decimating statistics capture: arm/trigger/hold-off, then per-channel block mean/min/max/p-p.
// Optional DECIM_STAT_ROUND_EN selects round-half-up saturated mean instead of floor.
module decim_stat_capture #(
  parameter int DW      = 16,
  parameter int NCHAN   = 2,
  parameter int MAXLOG2 = 20,
  parameter int MEMAW   = 10,
  parameter int LW      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trig,
  input  logic                  cont,
  input  logic [LW-1:0]         log2n,
  input  logic [31:0]           dt,
  input  logic [MEMAW-1:0]      npts,
  input  logic [1:0]            opsel,
  input  logic [NCHAN*DW-1:0]   din,
  output logic [NCHAN*DW-1:0]   dout,
  output logic                  dvalid,
  output logic [MEMAW-1:0]      addr,
  output logic                  busy,
  output logic                  done
);

  localparam int AW = DW + MAXLOG2;

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_HOLDOFF, S_RUN, S_DONE} state_t;

  state_t               state_r, state_nxt_s;
  logic                 cont_r;
  logic [LW-1:0]        l2_r;
  logic [MAXLOG2-1:0]   mask_r, scnt_r;
  logic [31:0]          dt_r, hcnt_r;
  logic [MEMAW-1:0]     npm1_r, widx_r, fin_addr_r, addr_r;
  logic [1:0]           op_r;
  logic                 fin_v_r, dvalid_r, busy_r, done_r;

  logic [LW-1:0]        l2_in_s;
  logic                 arm_ok_s, run_s, last_s, final_s, trig_go_s;

  assign l2_in_s   = (log2n > LW'(MAXLOG2)) ? LW'(MAXLOG2) : log2n;
  assign arm_ok_s  = arm & ~abort & ((state_r == S_IDLE) | (state_r == S_DONE));
  assign run_s     = (state_r == S_RUN);
  assign last_s    = run_s & (scnt_r == mask_r);
  assign final_s   = last_s & (widx_r == npm1_r);
  assign trig_go_s = (state_r == S_ARMED) & trig;

  // Next-state decode; abort has priority over everything else
  always_comb begin
    state_nxt_s = state_r;
    if (abort) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:    if (arm) state_nxt_s = S_ARMED; else state_nxt_s = S_IDLE;
        S_ARMED:   if (trig) state_nxt_s = (dt_r == 32'd0) ? S_RUN : S_HOLDOFF;
                   else state_nxt_s = S_ARMED;
        S_HOLDOFF: if (hcnt_r == 32'd0) state_nxt_s = S_RUN; else state_nxt_s = S_HOLDOFF;
        S_RUN:     if (final_s) state_nxt_s = cont_r ? S_ARMED : S_DONE; else state_nxt_s = S_RUN;
        S_DONE:    if (arm) state_nxt_s = S_ARMED; else state_nxt_s = S_DONE;
        default:   state_nxt_s = S_IDLE;
      endcase
    end
  end

  // Control state, config latch, counters and the two-stage result pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      cont_r     <= 1'b0;
      l2_r       <= {LW{1'b0}};
      mask_r     <= {MAXLOG2{1'b0}};
      dt_r       <= 32'd0;
      npm1_r     <= {MEMAW{1'b0}};
      op_r       <= 2'd0;
      hcnt_r     <= 32'd0;
      scnt_r     <= {MAXLOG2{1'b0}};
      widx_r     <= {MEMAW{1'b0}};
      fin_v_r    <= 1'b0;
      fin_addr_r <= {MEMAW{1'b0}};
      dvalid_r   <= 1'b0;
      addr_r     <= {MEMAW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == S_ARMED) | (state_nxt_s == S_HOLDOFF) | (state_nxt_s == S_RUN);
      done_r  <= (state_nxt_s == S_DONE);
      if (arm_ok_s) begin
        cont_r <= cont;
        l2_r   <= l2_in_s;
        mask_r <= ~({MAXLOG2{1'b1}} << l2_in_s);
        dt_r   <= dt;
        npm1_r <= npts - MEMAW'(1);   // npts==0 wraps to all-ones: 2^MEMAW results
        op_r   <= opsel;
      end
      if (trig_go_s) begin
        hcnt_r <= dt_r - 32'd1;
      end else if ((state_r == S_HOLDOFF) && (hcnt_r != 32'd0)) begin
        hcnt_r <= hcnt_r - 32'd1;
      end
      if (abort) begin
        scnt_r <= {MAXLOG2{1'b0}};
        widx_r <= {MEMAW{1'b0}};
      end else if (last_s) begin
        scnt_r <= {MAXLOG2{1'b0}};
        widx_r <= final_s ? {MEMAW{1'b0}} : widx_r + MEMAW'(1);
      end else if (run_s) begin
        scnt_r <= scnt_r + MAXLOG2'(1);
      end
      fin_v_r <= last_s & ~abort;
      if (last_s) fin_addr_r <= widx_r;
      dvalid_r <= fin_v_r & ~abort;
      if (fin_v_r & ~abort) addr_r <= fin_addr_r;
    end
  end

  assign dvalid = dvalid_r;
  assign addr   = addr_r;
  assign busy   = busy_r;
  assign done   = done_r;

`ifdef DECIM_STAT_ROUND_EN
  localparam logic signed [AW:0] SAT_HI = $signed({{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}});
  localparam logic signed [AW:0] SAT_LO = $signed({{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}});
  logic [AW:0] half_s;
  assign half_s = (l2_r == {LW{1'b0}}) ? {(AW+1){1'b0}}
                                       : ({{AW{1'b0}}, 1'b1} << (l2_r - LW'(1)));
`endif

  for (genvar c = 0; c < NCHAN; c++) begin : g_ch
    logic signed [DW-1:0] x_s, min_r, max_r, min_nxt_s, max_nxt_s, mean_s, res_s, res_r;
    logic signed [AW-1:0] sum_r, sum_nxt_s, xext_s;

    assign x_s    = din[c*DW +: DW];
    assign xext_s = {{MAXLOG2{x_s[DW-1]}}, x_s};

    // Running window statistics; first sample of a window reloads them
    always_comb begin
      if (scnt_r == {MAXLOG2{1'b0}}) begin
        sum_nxt_s = xext_s;
        min_nxt_s = x_s;
        max_nxt_s = x_s;
      end else begin
        sum_nxt_s = sum_r + xext_s;
        min_nxt_s = (x_s < min_r) ? x_s : min_r;
        max_nxt_s = (x_s > max_r) ? x_s : max_r;
      end
    end

`ifdef DECIM_STAT_ROUND_EN
    logic signed [AW:0] rq_s;
    assign rq_s = ($signed({sum_r[AW-1], sum_r}) + $signed(half_s)) >>> l2_r;
    // Saturate the rounded mean into the signed sample range
    always_comb begin
      if (rq_s > SAT_HI) begin
        mean_s = {1'b0, {(DW-1){1'b1}}};
      end else if (rq_s < SAT_LO) begin
        mean_s = {1'b1, {(DW-1){1'b0}}};
      end else begin
        mean_s = rq_s[DW-1:0];
      end
    end
`else
    assign mean_s = DW'(sum_r >>> l2_r);
`endif

    // Result select for the completed window
    always_comb begin
      case (op_r)
        2'd0:    res_s = mean_s;
        2'd1:    res_s = min_r;
        2'd2:    res_s = max_r;
        2'd3:    res_s = max_r - min_r;
        default: res_s = mean_s;
      endcase
    end

    // Accumulators and registered result word
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sum_r <= {AW{1'b0}};
        min_r <= {DW{1'b0}};
        max_r <= {DW{1'b0}};
        res_r <= {DW{1'b0}};
      end else begin
        if (run_s) begin
          sum_r <= sum_nxt_s;
          min_r <= min_nxt_s;
          max_r <= max_nxt_s;
        end
        if (fin_v_r & ~abort) res_r <= res_s;
      end
    end

    assign dout[c*DW +: DW] = res_r;
  end

endmodule

// File: tb/tb_decim_stat_capture.sv
// Self-checking bench for decim_stat_capture: directed captures plus random ones against a sample-history model.
module tb_decim_stat_capture;
  localparam int DW = 16, NCHAN = 2, MEMAW = 10, LW = 5, HLEN = 8192;

  logic clk = 1'b0, reset = 1'b1, arm = 1'b0, abort = 1'b0, trig = 1'b0, cont = 1'b0;
  logic [LW-1:0] log2n = '0;
  logic [31:0] dt = '0;
  logic [MEMAW-1:0] npts = '0;
  logic [1:0] opsel = '0;
  logic [NCHAN*DW-1:0] din = '0;
  logic [NCHAN*DW-1:0] dout;
  logic dvalid, busy, done;
  logic [MEMAW-1:0] addr;

  decim_stat_capture #(.DW(DW), .NCHAN(NCHAN), .MAXLOG2(20), .MEMAW(MEMAW), .LW(LW)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trig(trig), .cont(cont),
    .log2n(log2n), .dt(dt), .npts(npts), .opsel(opsel), .din(din),
    .dout(dout), .dvalid(dvalid), .addr(addr), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] din_hist [HLEN];
  typedef struct { int c; int a; logic [31:0] d; } ev_t;
  ev_t ev_q[$];
  ev_t exp_q[$];

  always @(negedge clk) if (dvalid === 1'b1) ev_q.push_back('{cyc, int'(addr), dout});

  int n_pass = 0, n_total = 0;
  int mode = 0, base = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic tick();
    int p;
    @(posedge clk);
    #1;
    p = cyc - base;
    case (mode)
      1: din = {((p & 1) != 0) ? 16'h7FFF : 16'h8000, 16'(p)};
      2: din = {16'($urandom()), ((p & 3) >= 2) ? 16'd1 : 16'd0};
      default: din = $urandom();
    endcase
    if (cyc < HLEN) din_hist[cyc] = din;
  endtask

  task automatic step(input logic a, input logic t, input logic ab, output int at);
    arm = a; trig = t; abort = ab; at = cyc;
    tick();
    arm = 1'b0; trig = 1'b0; abort = 1'b0;
  endtask

  task automatic idle(input int n);
    int x;
    repeat (n) step(1'b0, 1'b0, 1'b0, x);
  endtask

  function automatic logic [15:0] model_ch(input int first, input int l2, input int op, input int ch);
    longint s = 0, q;
    int mn = 32767, mx = -32768, v;
    logic [31:0] w;
    for (int i = 0; i < (1 << l2); i++) begin
      w = din_hist[first + i];
      v = (ch == 0) ? int'($signed(w[15:0])) : int'($signed(w[31:16]));
      s += v;
      if (v < mn) mn = v;
      if (v > mx) mx = v;
    end
    case (op)
      0: begin
`ifdef DECIM_STAT_ROUND_EN
        if (l2 > 0) s = s + (longint'(1) << (l2 - 1));
        q = s >>> l2;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
`else
        q = s >>> l2;
`endif
        return q[15:0];
      end
      1: return mn[15:0];
      2: return mx[15:0];
      default: return 16'(mx - mn);
    endcase
  endfunction

  task automatic add_exp(input int t, input int d, input int l2, input int np, input int op);
    int n = 1 << l2;
    int first;
    for (int k = 0; k < np; k++) begin
      first = t + 1 + d + k * n;
      exp_q.push_back('{first + n + 1, k, {model_ch(first, l2, op, 1), model_ch(first, l2, op, 0)}});
    end
  endtask

  function automatic logic [31:0] ev_d(input int k);
    return (k < ev_q.size()) ? ev_q[k].d : 32'hxxxxxxxx;
  endfunction

  function automatic int ev_c(input int k);
    return (k < ev_q.size()) ? ev_q[k].c : -1;
  endfunction

  task automatic cmp_events(input string tag);
    int n;
    chk({tag, ".count"}, 64'(ev_q.size()), 64'(exp_q.size()));
    n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d].cyc", tag, i), 64'(ev_q[i].c), 64'(exp_q[i].c));
      chk($sformatf("%s[%0d].addr", tag, i), 64'(ev_q[i].a), 64'(exp_q[i].a));
      chk($sformatf("%s[%0d].dout", tag, i), 64'(ev_q[i].d), 64'(exp_q[i].d));
    end
  endtask

  // Arm with trig in the same cycle (must be ignored), then scramble the config ports.
  task automatic arm_cfg(input int l2, input int d, input int np, input int op, input logic c);
    int x;
    ev_q.delete(); exp_q.delete();
    log2n = LW'(l2); dt = 32'(d); npts = MEMAW'(np); opsel = 2'(op); cont = c;
    step(1'b1, 1'b1, 1'b0, x);
    log2n = LW'($urandom()); dt = $urandom(); npts = MEMAW'($urandom());
    opsel = 2'($urandom()); cont = 1'($urandom());
    idle(3);
    chk("armed.busy", 64'(busy), 64'd1);
    chk("trig_with_arm.no_dvalid", 64'(ev_q.size()), 64'd0);
  endtask

  task automatic capture(input string tag, input int l2, input int d, input int np, input int op,
                         input int md, output int t);
    int npe = (np == 0) ? 1024 : np;
    mode = md;
    arm_cfg(l2, d, np, op, 1'b0);
    base = cyc + 1 + d;
    step(1'b0, 1'b1, 1'b0, t);
    idle(d + npe * (1 << l2) + 4);
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    add_exp(t, d, l2, npe, op);
    cmp_events(tag);
  endtask

  initial begin
    int t, t1, t2, t3, x, op;
    logic [15:0] t1_exp [4];
`ifdef DECIM_STAT_ROUND_EN
    t1_exp = '{16'd2, 16'd6, 16'd10, 16'd14};
`else
    t1_exp = '{16'd1, 16'd5, 16'd9, 16'd13};
`endif
    repeat (3) tick();
    chk("reset.dout", 64'(dout), 64'd0);
    chk("reset.dvalid", 64'(dvalid), 64'd0);
    chk("reset.addr", 64'(addr), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    reset = 1'b0;
    idle(2);

    // abort wins over arm
    step(1'b1, 1'b0, 1'b1, x);
    idle(1);
    chk("abort_beats_arm.busy", 64'(busy), 64'd0);

    // T1 ramp, floor mean
    capture("t1", 2, 0, 4, 0, 1, t);
    for (int k = 0; k < 4; k++) chk($sformatf("t1.mean%0d", k), 64'(ev_d(k) & 32'hFFFF), 64'(t1_exp[k]));
    chk("t1.latency", 64'(ev_c(0)), 64'(t + 6));

    // T2 min/max/p-p on extremes
    for (int o = 1; o <= 3; o++) begin
      capture($sformatf("t2.op%0d", o), 1, 0, 2, o, 1, t);
      chk($sformatf("t2.op%0d.ch1", o), 64'(ev_d(0) >> 16),
          (o == 1) ? 64'h8000 : (o == 2) ? 64'h7FFF : 64'hFFFF);
    end

    // T3 hold-off with pass-through decimation
    capture("t3", 0, 10, 3, 0, 0, t);
    chk("t3.first_cyc", 64'(ev_c(0)), 64'(t + 13));
    chk("t3.first_dout", 64'(ev_d(0)), 64'(din_hist[t + 11]));

    // T4 rounding boundary 0,0,1,1
    capture("t4", 2, 0, 2, 0, 2, t);
`ifdef DECIM_STAT_ROUND_EN
    chk("t4.mean", 64'(ev_d(0) & 32'hFFFF), 64'd1);
`else
    chk("t4.mean", 64'(ev_d(0) & 32'hFFFF), 64'd0);
`endif

    // random configurations
    for (int r = 0; r < 6; r++)
      capture($sformatf("rnd%0d", r), $urandom_range(0, 4), $urandom_range(0, 5),
              $urandom_range(1, 6), $urandom_range(0, 3), 0, t);

    // npts = 0 means a full 2^MEMAW results
    capture("npts0", 0, 0, 0, 3, 0, t);

    // T5 auto-rearm, immediate retrigger, then abort with a strobe pending
    mode = 0;
    op = $urandom_range(0, 3);
    arm_cfg(2, 1, 2, op, 1'b1);
    step(1'b0, 1'b1, 1'b0, t1);
    idle(9);
    step(1'b0, 1'b1, 1'b0, t2);
    idle(13);
    chk("t5.done_never", 64'(done), 64'd0);
    chk("t5.rearmed", 64'(busy), 64'd1);
    step(1'b0, 1'b1, 1'b0, t3);
    idle(5);
    step(1'b0, 1'b0, 1'b1, x);
    idle(6);
    chk("t5.abort.busy", 64'(busy), 64'd0);
    chk("t5.abort.done", 64'(done), 64'd0);
    add_exp(t1, 1, 2, 2, op);
    add_exp(t2, 1, 2, 2, op);
    cmp_events("t5");

    // T6 asynchronous reset mid-run
    arm_cfg(3, 0, 4, 2, 1'b0);
    step(1'b0, 1'b1, 1'b0, t);
    idle(10);
    #3 reset = 1'b1;
    #1;
    chk("t6.dout", 64'(dout), 64'd0);
    chk("t6.dvalid", 64'(dvalid), 64'd0);
    chk("t6.addr", 64'(addr), 64'd0);
    chk("t6.busy", 64'(busy), 64'd0);
    chk("t6.done", 64'(done), 64'd0);
    #2 reset = 1'b0;
    tick();
    capture("t6.after", 1, 0, 2, 0, 0, t);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
